// File: rtl/masked_sram_pkg.sv
// Shared types, latency bounds and parameter-legality check for the masked
// single-port SRAM model.
package masked_sram_pkg;

  typedef enum logic {CLEAR, READY} sram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit params_legal(input int depth, input int width,
                                      input int mask_gran, input int rd_lat);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (mask_gran > 0) && ((width % mask_gran) == 0) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/masked_sram_rw_ext_if.sv
// Request/response bundle of the RW0 port; the SRAM is the slave side.
interface masked_sram_rw_ext_if #(
  parameter int ADDR_W   = 6,
  parameter int WIDTH    = 34,
  parameter int MASK_SEG = 2
);
  logic [ADDR_W-1:0]   addr;
  logic                en;
  logic                wmode;
  logic [MASK_SEG-1:0] wmask;
  logic [WIDTH-1:0]    wdata;
  logic                ready;
  logic                rvalid;
  logic [WIDTH-1:0]    rdata;

  modport master (output addr, en, wmode, wmask, wdata,
                  input  ready, rvalid, rdata);
  modport slave  (input  addr, en, wmode, wmask, wdata,
                  output ready, rvalid, rdata);
endinterface

// File: rtl/masked_sram_clear_seq.sv
// Post-reset clear sequencer: sweeps every word once, then holds ready high
// until the next reset.
module masked_sram_clear_seq
  import masked_sram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        // The pointer parks on the last word rather than wrapping.
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = READY;
        else                             ptr_d   = ptr_q + ADDR_W'(1);
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = ptr_q;
  assign ready    = (state_q == READY);

endmodule

// File: rtl/masked_sram_rw_ext.sv
// Single-port masked SRAM model with clear-on-reset sweep, RD_LAT-deep read
// pipeline and a held, registered read-data output.
module masked_sram_rw_ext
  import masked_sram_pkg::*;
#(
  parameter int               DEPTH     = 64,
  parameter int               WIDTH     = 34,
  parameter int               MASK_GRAN = 17,
  parameter int               RD_LAT    = 1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input logic                 RW0_clk,
  input logic                 RW0_rst_n,
  masked_sram_rw_ext_if.slave RW0
);

  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int MASK_SEG = WIDTH / MASK_GRAN;

  if (!params_legal(DEPTH, WIDTH, MASK_GRAN, RD_LAT)) begin : g_bad_params
    $error("masked_sram_rw_ext: illegal DEPTH/WIDTH/MASK_GRAN/RD_LAT");
  end

  logic [WIDTH-1:0]    ram [DEPTH];
  logic                clr_we, ready;
  logic [ADDR_W-1:0]   clr_addr;
  logic                wr_en, rd_acc;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [MASK_SEG-1:0] wr_mask;

  masked_sram_clear_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (RW0_clk),
    .rst_n    (RW0_rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // ready is low for the whole sweep, so user traffic never competes with it.
  assign rd_acc  = RW0.en && ready && !RW0.wmode;
  assign wr_en   = clr_we || (RW0.en && ready && RW0.wmode);
  assign wr_addr = clr_we ? clr_addr : RW0.addr;
  assign wr_data = clr_we ? INIT_VAL : RW0.wdata;
  assign wr_mask = clr_we ? '1       : RW0.wmask;

  always_ff @(posedge RW0_clk) begin
    for (int s = 0; s < MASK_SEG; s++) begin
      if (wr_en && wr_mask[s])
        ram[wr_addr][s*MASK_GRAN +: MASK_GRAN] <= wr_data[s*MASK_GRAN +: MASK_GRAN];
    end
  end

  // ---- stage p0: array sampled at acceptance ----
  logic             vld_p0, vld_out;
  logic [WIDTH-1:0] data_p0, data_out;

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) vld_p0 <= 1'b0;
    else            vld_p0 <= rd_acc;
  end

  always_ff @(posedge RW0_clk) begin
    if (rd_acc) data_p0 <= ram[RW0.addr];
  end

  // ---- stage p1: extra delay slot, present only for RD_LAT = 2 ----
  if (RD_LAT == 2) begin : g_lat2
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) vld_p1 <= 1'b0;
      else            vld_p1 <= vld_p0;
    end

    always_ff @(posedge RW0_clk) begin
      if (vld_p0) data_p1 <= data_p0;
    end

    assign vld_out  = vld_p1;
    assign data_out = data_p1;
  end else begin : g_lat1
    assign vld_out  = vld_p0;
    assign data_out = data_p0;
  end

  // ---- output register: rdata only moves when a read completes ----
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= vld_out;
      if (vld_out) rdata_q <= data_out;
    end
  end

  assign RW0.ready  = ready;
  assign RW0.rvalid = rvalid_q;
  assign RW0.rdata  = rdata_q;

endmodule
